// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: expands RISC-V style immediates and
// registers them behind a two-slot (output + skid) valid/ready buffer.

package imm_gen_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_C    = 3'd6
    } imm_type_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_t       typ;
    } imm_entry_t;

endpackage

module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter bit ZERO_NONE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  imm_type_t       in_imm_type,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output imm_type_t       out_imm_type
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t     state;
    imm_entry_t skid;
    imm_entry_t new_entry;
    logic       accept;
    logic       drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    // Immediate expansion; undefined type encodings fall back to IMM_NONE.
    always_comb begin
        new_entry.imm = '0;
        new_entry.typ = IMM_NONE;
        case (in_imm_type)
            IMM_I: begin
                new_entry.imm = {{20{in_instr[31]}}, in_instr[31:20]};
                new_entry.typ = IMM_I;
            end
            IMM_S: begin
                new_entry.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                new_entry.typ = IMM_S;
            end
            IMM_B: begin
                new_entry.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
                new_entry.typ = IMM_B;
            end
            IMM_U: begin
                new_entry.imm = {in_instr[31:12], 12'h000};
                new_entry.typ = IMM_U;
            end
            IMM_J: begin
                new_entry.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                new_entry.typ = IMM_J;
            end
            IMM_C: begin
                new_entry.imm = {27'h0, in_instr[19:15]};
                new_entry.typ = IMM_C;
            end
            default: begin
                new_entry.imm = ZERO_NONE ? XLEN'(0) : in_instr;
                new_entry.typ = IMM_NONE;
            end
        endcase
    end

    // Slot control; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_EMPTY;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_imm_type <= IMM_NONE;
            skid         <= '{imm: '0, typ: IMM_NONE};
        end else if (flush) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_imm      <= new_entry.imm;
                        out_imm_type <= new_entry.typ;
                        out_valid    <= 1'b1;
                        state        <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        out_imm      <= new_entry.imm;
                        out_imm_type <= new_entry.typ;
                    end else if (accept) begin
                        skid     <= new_entry;
                        in_ready <= 1'b0;
                        state    <= ST_FULL;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        out_imm      <= skid.imm;
                        out_imm_type <= skid.typ;
                        in_ready     <= 1'b1;
                        state        <= ST_ONE;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: format table, backpressure, streaming,
// flush and mid-operation reset sequences.

module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    imm_type_t   in_imm_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    imm_type_t   out_imm_type;

    int n_tests = 0;
    int n_fail  = 0;

    imm_gen_stage #(.ZERO_NONE(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_imm_type  (in_imm_type),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_imm      (out_imm),
        .out_imm_type (out_imm_type)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        imm_type_t   typ;
        logic [31:0] exp_imm;
        imm_type_t   exp_typ;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input imm_type_t t, input logic rdy);
        in_valid    = v;
        in_instr    = instr;
        in_imm_type = t;
        out_ready   = rdy;
    endtask

    initial begin
        vecs[0] = '{32'hFFF00093, IMM_I,    32'hFFFFFFFF, IMM_I};
        vecs[1] = '{32'hFE20AE23, IMM_S,    32'hFFFFFFFC, IMM_S};
        vecs[2] = '{32'hFE000CE3, IMM_B,    32'hFFFFFFF8, IMM_B};
        vecs[3] = '{32'h123450B7, IMM_U,    32'h12345000, IMM_U};
        vecs[4] = '{32'hFFDFF0EF, IMM_J,    32'hFFFFFFFC, IMM_J};
        vecs[5] = '{32'h300FD073, IMM_C,    32'h0000001F, IMM_C};
        vecs[6] = '{32'hDEADBEEF, IMM_NONE, 32'h00000000, IMM_NONE};
        vecs[7] = '{32'hDEADBEEF, imm_type_t'(3'd7), 32'h00000000, IMM_NONE};
        vecs[8] = '{32'h00500093, IMM_I,    32'h00000005, IMM_I};
        vecs[9] = '{32'h00812223, IMM_S,    32'h00000004, IMM_S};

        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, IMM_NONE, 1'b1);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_imm",   out_imm,        32'h0);
        chk("rst_out_type",  32'(out_imm_type), 32'(IMM_NONE));
        rst_n = 1'b1;

        // Format table: one accept, result visible one cycle later, then drains.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].typ, 1'b1);
            tick();
            drive(1'b0, 32'h0, IMM_NONE, 1'b1);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_imm", i),   out_imm, vecs[i].exp_imm);
            chk($sformatf("vec%0d_type", i),  32'(out_imm_type), 32'(vecs[i].exp_typ));
            tick();
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Backpressure: A then B with out_ready low fills both slots.
        drive(1'b1, 32'hFFF00093, IMM_I, 1'b0);
        tick();
        chk("bp_in_ready_after_a", 32'(in_ready), 32'd1);
        drive(1'b1, 32'h123450B7, IMM_U, 1'b0);
        tick();
        drive(1'b0, 32'h0, IMM_NONE, 1'b0);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_out_imm",  out_imm, 32'hFFFFFFFF);
        chk("bp_full_valid",    32'(out_valid), 32'd1);
        tick();
        chk("bp_hold_imm",  out_imm, 32'hFFFFFFFF);
        chk("bp_hold_type", 32'(out_imm_type), 32'(IMM_I));
        out_ready = 1'b1;
        tick();
        chk("bp_b_imm",      out_imm, 32'h12345000);
        chk("bp_b_type",     32'(out_imm_type), 32'(IMM_U));
        chk("bp_in_ready_b", 32'(in_ready), 32'd1);
        tick();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming: 16 back-to-back U-type words, one result per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, (32'(i + 1) << 12) | 32'h37, IMM_U, 1'b1);
            tick();
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_imm", i),   out_imm, 32'(i + 1) << 12);
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 32'h0, IMM_NONE, 1'b1);
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Flush while FULL with a simultaneous input and drain.
        drive(1'b1, 32'h00500093, IMM_I, 1'b0);
        tick();
        drive(1'b1, 32'h00812223, IMM_S, 1'b0);
        tick();
        chk("fl_full", 32'(in_ready), 32'd0);
        drive(1'b1, 32'h300FD073, IMM_C, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, IMM_NONE, 1'b1);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("fl_quiet%0d", i), 32'(out_valid), 32'd0);
        end

        // Reset for one cycle while FULL, then a fresh accept.
        drive(1'b1, 32'hFFF00093, IMM_I, 1'b0);
        tick();
        drive(1'b1, 32'h123450B7, IMM_U, 1'b0);
        tick();
        chk("rs_full", 32'(in_ready), 32'd0);
        drive(1'b0, 32'h0, IMM_NONE, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rs_out_valid", 32'(out_valid), 32'd0);
        chk("rs_out_imm",   out_imm, 32'h0);
        chk("rs_out_type",  32'(out_imm_type), 32'(IMM_NONE));
        chk("rs_in_ready",  32'(in_ready), 32'd1);
        drive(1'b1, 32'hFFDFF0EF, IMM_J, 1'b1);
        tick();
        drive(1'b0, 32'h0, IMM_NONE, 1'b1);
        chk("rs_accept_valid", 32'(out_valid), 32'd1);
        chk("rs_accept_imm",   out_imm, 32'hFFFFFFFC);
        chk("rs_accept_type",  32'(out_imm_type), 32'(IMM_J));
        tick();
        chk("rs_accept_drained", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
